pirate_uart_tx: RTL

- Downstream stage of pirate_cipher.
- Accepts the byte stream on data_out/data_out_valid into an internal FIFO and serialises it on an 8N1 UART line.
- Encoding expands consonants to three bytes, so the FIFO absorbs bursts. fifo_almost_full is fed back to hold off the producer.
- Sits between the cipher core and the chip-level txd pin.

---
 rtl/pirate_pkg.sv | 18 +
 rtl/pirate_uart_tx_if.sv | 15 +
 rtl/pirate_byte_fifo.sv | 58 +++++
 rtl/pirate_uart_tx.sv | 99 +++++++++
 4 files changed

// File: rtl/pirate_pkg.sv
// Shared constants for the pirate cipher / UART transmit path.
package pirate_pkg;
  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;
  localparam int   UART_DATA_BITS = 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic [7:0] ASCII_O = 8'h6F;

  typedef struct packed {
    logic       vld;
    logic [7:0] data;
  } byte_req_t;
endpackage

// File: rtl/pirate_uart_tx_if.sv
// Producer-side byte stream and FIFO status between pirate_cipher and pirate_uart_tx.
interface pirate_uart_tx_if #(parameter int FIFO_DEPTH = 16);
  logic [7:0]                  data_in;
  logic                        data_in_valid;
  logic                        clear_overflow;
  logic                        fifo_full;
  logic                        fifo_almost_full;
  logic [$clog2(FIFO_DEPTH):0] fill_count;
  logic                        overflow;

  modport master (output data_in, data_in_valid, clear_overflow,
                  input  fifo_full, fifo_almost_full, fill_count, overflow);
  modport slave  (input  data_in, data_in_valid, clear_overflow,
                  output fifo_full, fifo_almost_full, fill_count, overflow);
endinterface

// File: rtl/pirate_byte_fifo.sv
// Byte FIFO with fill count, full/almost-full decode and sticky overflow on dropped writes.
module pirate_byte_fifo
  import pirate_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12
) (
  input  logic                       clk,
  input  logic                       reset_l,
  input  byte_req_t                  wr,
  input  logic                       rd_en,
  input  logic                       clear_overflow,
  output logic [7:0]                 rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       almost_full,
  output logic                       empty,
  output logic                       empty_nxt,
  output logic                       overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][7:0] mem;
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count_nxt;
  logic                  push, pop, drop;

  assign full        = count == CW'(DEPTH);
  assign almost_full = count >= CW'(AF_LEVEL);
  assign empty       = count == '0;
  // a pop in the same cycle never makes room for a write arriving while full
  assign push        = wr.vld && !full;
  assign drop        = wr.vld && full;
  assign pop         = rd_en && !empty;
  assign count_nxt   = count + CW'(push) - CW'(pop);
  assign empty_nxt   = count_nxt == '0;
  assign rd_data     = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      if (drop)                overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr.data;
  end
endmodule

// File: rtl/pirate_uart_tx.sv
// Buffers the cipher byte stream and serialises it as 8N1 UART on txd.
module pirate_uart_tx
  import pirate_pkg::*;
#(
  parameter int FIFO_DEPTH        = 16,
  parameter int ALMOST_FULL_LEVEL = 12,
  parameter int CLK_DIV           = 434
) (
  input  logic                  clk,
  input  logic                  reset_l,
  pirate_uart_tx_if.slave       bus,
  output logic                  tx_busy,
  output logic                  txd
);
  localparam int              TW    = $clog2(CLK_DIV);
  localparam int              CW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [TW-1:0]   TLAST = TW'(CLK_DIV - 1);

  logic [1:0]    state, state_nxt;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shift, head;
  logic [CW-1:0] count;
  logic          pop, empty, empty_nxt, full, almost_full, overflow, bit_end;
  byte_req_t     wr;

  assign wr = '{vld: bus.data_in_valid, data: bus.data_in};

  pirate_byte_fifo #(.DEPTH(FIFO_DEPTH), .AF_LEVEL(ALMOST_FULL_LEVEL)) u_fifo (
    .clk            (clk),
    .reset_l        (reset_l),
    .wr             (wr),
    .rd_en          (pop),
    .clear_overflow (bus.clear_overflow),
    .rd_data        (head),
    .count          (count),
    .full           (full),
    .almost_full    (almost_full),
    .empty          (empty),
    .empty_nxt      (empty_nxt),
    .overflow       (overflow)
  );

  assign bus.fill_count       = count;
  assign bus.fifo_full        = full;
  assign bus.fifo_almost_full = almost_full;
  assign bus.overflow         = overflow;

  assign bit_end = timer == TLAST;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE:  if (!empty) begin pop = 1'b1; state_nxt = START; end
      START: if (bit_end) state_nxt = DATA;
      DATA:  if (bit_end && bit_idx == 3'(UART_DATA_BITS - 1)) state_nxt = STOP;
      // chaining straight into the next start bit keeps frames gap-free
      STOP:  if (bit_end) begin
               if (!empty) begin pop = 1'b1; state_nxt = START; end
               else state_nxt = IDLE;
             end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state   <= IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shift   <= '0;
      txd     <= UART_STOP_BIT;
      tx_busy <= 1'b0;
    end else begin
      state   <= state_nxt;
      tx_busy <= (state_nxt != IDLE) || !empty_nxt;
      timer   <= (state == IDLE || bit_end) ? '0 : timer + TW'(1);
      if (pop) shift <= head;
      case (state)
        IDLE:  txd <= pop ? UART_START_BIT : UART_STOP_BIT;
        START: if (bit_end) begin
                 txd     <= shift[0];
                 bit_idx <= '0;
               end
        DATA:  if (bit_end) begin
                 if (state_nxt == STOP) txd <= UART_STOP_BIT;
                 else begin
                   txd     <= shift[1];
                   shift   <= shift >> 1;
                   bit_idx <= bit_idx + 3'd1;
                 end
               end
        STOP:  if (bit_end) txd <= pop ? UART_START_BIT : UART_STOP_BIT;
        default: txd <= UART_STOP_BIT;
      endcase
    end
  end
endmodule
